// File: rtl/sar_search.sv
// Successive-approximation search: drives TRIAL into an external unsigned <= comparator
// and decides one bit per DECIDE cycle, MSB first, converging on the comparator's X.
module sar_search #(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic             LE,
  output logic [WIDTH-1:0] TRIAL,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             VALID
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [3:0] LAT = 4'(CMP_LAT);

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] trial, trial_n;
  logic [WIDTH-1:0] result, result_n;
  logic [WIDTH-1:0] decided;
  logic [IDX_W-1:0] idx, idx_n, idx_dec;
  logic [3:0]       cnt, cnt_n;
  logic             busy, busy_n;
  logic             valid, valid_n;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      idx    <= IDX_TOP;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      trial  <= trial_n;
      result <= result_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      valid  <= valid_n;
    end
  end

  // decided is the current trial with this bit's verdict applied; only used in DECIDE
  always_comb begin
    state_n  = state;
    trial_n  = trial;
    result_n = result;
    idx_n    = idx;
    cnt_n    = cnt;
    busy_n   = busy;
    valid_n  = 1'b0;
    idx_dec  = idx - IDX_W'(1);
    decided  = trial;
    if (!LE) decided[idx] = 1'b0;

    if (state != IDLE && ABORT) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      trial_n = result;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (START && !ABORT) begin
            trial_n            = '0;
            trial_n[WIDTH-1]   = 1'b1;
            idx_n              = IDX_TOP;
            busy_n             = 1'b1;
            if (CMP_LAT > 0) begin
              state_n = SETTLE;
              cnt_n   = LAT;
            end else begin
              state_n = DECIDE;
            end
          end
        end
        SETTLE: begin
          if (cnt == 4'd1) begin
            state_n = DECIDE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        DECIDE: begin
          if (idx == '0) begin
            result_n = decided;
            trial_n  = decided;
            valid_n  = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
          end else begin
            trial_n          = decided;
            trial_n[idx_dec] = 1'b1;
            idx_n            = idx_dec;
            if (CMP_LAT > 0) begin
              state_n = SETTLE;
              cnt_n   = LAT;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign TRIAL  = trial;
  assign RESULT = result;
  assign BUSY   = busy;
  assign VALID  = valid;

endmodule
